alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter that shares one adder/comparator slice of the ALU between two requesters: the execute stage (port 0) and the address-generation/LSU path (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block drives the shared operands combinationally and registers each result into a per-requester response slot.
- Result latency is one cycle after acceptance.

Parameters:
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_op  in  2  per-requester op: 0 = add, 1 = compare.
- req_a  in  2*XLEN  per-requester operand A; bits [XLEN-1:0] are requester 0.
- req_b  in  2*XLEN  per-requester operand B.
- req_lsx  in  6  per-requester 3-bit compare control; bits [2:0] are requester 0.
  - bit0 = invert result.
  - bit1 = 0 for equality, 1 for less-than.
  - bit2 = 0 for signed less-than, 1 for unsigned less-than.
- rsp_valid  out  2  per-requester response slot full.
- rsp_data  out  2*XLEN  per-requester result.
- rsp_ready  in  2  per-requester response consumed.
- alu_a  out  XLEN  operand A to the shared slice.
- alu_b  out  XLEN  operand B to the shared slice.
- alu_lsx  out  3  compare control to the shared slice.
- alu_add_o  in  XLEN  sum returned by the slice (alu_a + alu_b, combinational).
- alu_cmp_o  in  1  compare result returned by the slice (combinational).

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid = 0, rsp_data = 0.
  - Priority pointer = 0, so requester 0 wins ties.
  - Any in-flight result is discarded.
  - Reset overrides every simultaneous event.
- Eligibility: elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]).
  - A requester whose slot is full and not draining is skipped.
  - A skipped requester does not block the other requester.
- Grant (combinational, one-hot or zero):
  - Only one requester eligible: it is granted.
  - Both eligible: the requester named by the pointer is granted.
  - Neither eligible: no grant.
- req_ready[i] = grant[i]. A request is accepted when req_valid[i] & req_ready[i].
- Pointer update: after a grant to requester i, the pointer becomes 1-i. With no grant, the pointer holds.
  - Under continuous contention, grants therefore alternate 0,1,0,1.
- Shared-slice drive:
  - On grant to requester i: alu_a/alu_b/alu_lsx = requester i's fields.
  - With no grant: alu_a, alu_b and alu_lsx are driven to 0.
- Result capture at the edge where requester i is accepted:
  - op = 0: rsp_data[i] = alu_add_o, modulo 2^XLEN with no carry-out.
  - op = 1: rsp_data[i] = {XLEN-1 zeros, alu_cmp_o}.
  - rsp_valid[i] is set to 1 at the same edge.
- Latency: a request accepted in cycle N shows rsp_valid=1 in cycle N+1.
  - Throughput is one op per cycle in total.
  - Each requester can sustain one op per cycle when it is alone and rsp_ready is held high.
- Slot rules:
  - rsp_valid[i] & rsp_ready[i] with no new acceptance: clear rsp_valid[i]. rsp_data[i] holds its last value.
  - rsp_valid[i] & rsp_ready[i] with a new acceptance in the same cycle: the slot is refilled; rsp_valid stays 1 and rsp_data takes the new value.
  - rsp_valid[i] & ~rsp_ready[i]: rsp_data[i] and rsp_valid[i] hold stable.
  - rsp_ready with rsp_valid=0 has no effect.
- Requests may be withdrawn or changed freely while not granted. There is no stability requirement before acceptance.
- Request fields of the non-granted requester never affect the alu_* outputs.

Test Plan:
- Reset, then req0 add a=0x0000_0005 b=0x0000_0007, rsp_ready=1 -> req_ready=01 same cycle; next cycle rsp_valid[0]=1, rsp_data[0]=0x0000_000C; alu_* = 0 when idle.
- Both requesters request continuously for 4 cycles, both rsp_ready=1:
  - req0 add 1+1, req1 cmp lsx=010 with a=0xFFFF_FFFF b=0x0000_0001.
  - Expect grants 0,1,0,1.
  - rsp_data[0]=0x2; rsp_data[1]=0x1 (signed -1<1).
- Same compare with lsx=110 (unsigned) -> rsp_data[1]=0x0. lsx=111 -> 0x1. lsx=001 with a=b=0x1234 -> 0x0.
- Backpressure:
  - req0 slot full with rsp_ready[0]=0, req0 and req1 both valid -> only req1 granted every cycle; rsp_data[0] stays stable.
  - Raise rsp_ready[0] -> req0 is granted in that same cycle and its slot is refilled with rsp_valid[0] continuously 1.
- Wrap-around: add 0xFFFF_FFFF+0x0000_0002 -> rsp_data=0x0000_0001.
- Reset mid-operation: assert rst in the cycle req1 is granted -> next cycle rsp_valid=00, rsp_data=0; first post-reset tie grants requester 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one add/compare ALU slice between
//   requester 0 (execute) and requester 1 (AGU/LSU). Each requester has a
//   valid/ready request channel and a one-entry registered response slot.
// Ports: req_* per-requester requests (packed, requester 0 in low bits),
//   rsp_* per-requester response slots, alu_* drive to / results from the
//   shared slice.
// Latency: result visible in the slot one cycle after acceptance.
// Backpressure: a requester whose slot is full and not draining is skipped
//   without blocking the other requester.
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_op,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [5:0]        req_lsx,
  output logic [1:0]        rsp_valid,
  output logic [2*XLEN-1:0] rsp_data,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_lsx,
  input  logic [XLEN-1:0]   alu_add_o,
  input  logic              alu_cmp_o
);

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              sel_op;
  logic [XLEN-1:0]   result;
  logic              ptr_q, ptr_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [2*XLEN-1:0] rsp_data_q, rsp_data_d;

  // A full slot can take a new result only in the cycle it is being drained.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  // Pointer only matters on a tie; otherwise the lone eligible requester wins.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = grant;

  // Slice operands come only from the granted requester; idle drives zero.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_lsx = '0;
    sel_op  = 1'b0;
    if (grant[0]) begin
      alu_a   = req_a[XLEN-1:0];
      alu_b   = req_b[XLEN-1:0];
      alu_lsx = req_lsx[2:0];
      sel_op  = req_op[0];
    end else if (grant[1]) begin
      alu_a   = req_a[2*XLEN-1:XLEN];
      alu_b   = req_b[2*XLEN-1:XLEN];
      alu_lsx = req_lsx[5:3];
      sel_op  = req_op[1];
    end
  end

  assign result = sel_op ? {{(XLEN-1){1'b0}}, alu_cmp_o} : alu_add_o;

  // Acceptance refills the slot even when it is draining the same cycle;
  // a drain without refill clears valid but keeps the old data.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (grant[0]) begin
      ptr_d                   = 1'b1;
      rsp_valid_d[0]          = 1'b1;
      rsp_data_d[XLEN-1:0]    = result;
    end else if (rsp_ready[0]) begin
      rsp_valid_d[0]          = 1'b0;
    end
    if (grant[1]) begin
      ptr_d                   = 1'b0;
      rsp_valid_d[1]          = 1'b1;
      rsp_data_d[2*XLEN-1:XLEN] = result;
    end else if (rsp_ready[1]) begin
      rsp_valid_d[1]          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb with a behavioural
//   model of the arbiter and a model of the shared add/compare slice.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b, rsp_data;
  logic [5:0]  req_lsx;
  logic [31:0] alu_a, alu_b, alu_add_o;
  logic [2:0]  alu_lsx;
  logic        alu_cmp_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_ptr;

  always #5 clk = ~clk;

  alu_share_arb #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_lsx(req_lsx),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_lsx(alu_lsx),
    .alu_add_o(alu_add_o), .alu_cmp_o(alu_cmp_o)
  );

  function automatic logic cmp_f(logic [31:0] a, logic [31:0] b, logic [2:0] lsx);
    logic r;
    if (!lsx[1])     r = (a == b);
    else if (lsx[2]) r = (a < b);
    else             r = ($signed(a) < $signed(b));
    return r ^ lsx[0];
  endfunction

  // Shared slice
  assign alu_add_o = alu_a + alu_b;
  assign alu_cmp_o = cmp_f(alu_a, alu_b, alu_lsx);

  function automatic logic [31:0] fa(int i); return i ? req_a[63:32] : req_a[31:0]; endfunction
  function automatic logic [31:0] fb(int i); return i ? req_b[63:32] : req_b[31:0]; endfunction
  function automatic logic [2:0]  fl(int i); return i ? req_lsx[5:3] : req_lsx[2:0]; endfunction

  function automatic logic [31:0] model_result(int i);
    if (req_op[i]) return {31'd0, cmp_f(fa(i), fb(i), fl(i))};
    return fa(i) + fb(i);
  endfunction

  // Who wins this cycle (-1 for nobody)
  function automatic int model_winner();
    bit c0, c1;
    c0 = req_valid[0] && (!m_valid[0] || rsp_ready[0]);
    c1 = req_valid[1] && (!m_valid[1] || rsp_ready[1]);
    if (c0 && c1) return m_ptr;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int w;
    w = model_winner();
    if (rst) begin
      m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      m_data[0]  = '0;   m_data[1]  = '0;
      m_ptr      = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i == w) begin
          m_data[i]  = model_result(i);
          m_valid[i] = 1'b1;
        end else if (rsp_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (w >= 0) m_ptr = 1 - w;
    end
  end

  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      w = model_winner();
      chk("m_req_ready", {62'd0, req_ready}, (w < 0) ? 64'd0 : (w == 0 ? 64'd1 : 64'd2));
      chk("m_alu_a",   {32'd0, alu_a},   (w < 0) ? 64'd0 : {32'd0, fa(w)});
      chk("m_alu_b",   {32'd0, alu_b},   (w < 0) ? 64'd0 : {32'd0, fb(w)});
      chk("m_alu_lsx", {61'd0, alu_lsx}, (w < 0) ? 64'd0 : {61'd0, fl(w)});
      chk("m_rsp_valid", {62'd0, rsp_valid}, {62'd0, m_valid[1], m_valid[0]});
      chk("m_rsp_data",  rsp_data, {m_data[1], m_data[0]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set0(logic op, logic [31:0] a, logic [31:0] b, logic [2:0] l);
    req_op[0] = op; req_a[31:0] = a; req_b[31:0] = b; req_lsx[2:0] = l;
  endtask

  task automatic set1(logic op, logic [31:0] a, logic [31:0] b, logic [2:0] l);
    req_op[1] = op; req_a[63:32] = a; req_b[63:32] = b; req_lsx[5:3] = l;
  endtask

  initial begin
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_data[0] = '0; m_data[1] = '0; m_ptr = 0;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_lsx = '0; rsp_ready = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state and single add
    chk("rst_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("idle_alu_a", {32'd0, alu_a}, 64'd0);
    rsp_ready = 2'b11;
    req_valid = 2'b01; set0(1'b0, 32'h5, 32'h7, 3'b000);
    #1 chk("add_rdy", {62'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 2'b00;
    chk("add_valid0", {63'd0, rsp_valid[0]}, 64'd1);
    chk("add_data0", {32'd0, rsp_data[31:0]}, 64'hC);
    #1 chk("idle_alu_b", {32'd0, alu_b}, 64'd0);

    // Contention after reset: alternate 0,1,0,1
    rst = 1'b1; cyc(); rst = 1'b0;
    set0(1'b0, 32'h1, 32'h1, 3'b000);
    set1(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", {62'd0, req_ready}, (k % 2) ? 64'd2 : 64'd1);
      cyc();
    end
    req_valid = 2'b00;
    chk("rr_data0", {32'd0, rsp_data[31:0]}, 64'h2);
    chk("rr_data1", {32'd0, rsp_data[63:32]}, 64'h1);

    // Compare variants on requester 1
    req_valid = 2'b10;
    set1(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b110); cyc();
    chk("cmp_ult", {32'd0, rsp_data[63:32]}, 64'h0);
    set1(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b111); cyc();
    chk("cmp_ult_inv", {32'd0, rsp_data[63:32]}, 64'h1);
    set1(1'b1, 32'h1234, 32'h1234, 3'b001); cyc();
    chk("cmp_ne", {32'd0, rsp_data[63:32]}, 64'h0);
    req_valid = 2'b00;

    // Backpressure on slot 0
    rsp_ready = 2'b10;
    req_valid = 2'b01; set0(1'b0, 32'h3, 32'h4, 3'b000); cyc();
    chk("bp_fill", {32'd0, rsp_data[31:0]}, 64'h7);
    set0(1'b0, 32'hA, 32'hA, 3'b000);
    set1(1'b0, 32'd100, 32'd200, 3'b000);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_grant1", {62'd0, req_ready}, 64'd2);
      cyc();
      chk("bp_hold_data0", {32'd0, rsp_data[31:0]}, 64'h7);
      chk("bp_hold_valid0", {63'd0, rsp_valid[0]}, 64'd1);
    end
    rsp_ready = 2'b11;
    #1 chk("bp_release_grant", {62'd0, req_ready}, 64'd1);
    cyc();
    chk("bp_refill_valid0", {63'd0, rsp_valid[0]}, 64'd1);
    chk("bp_refill_data0", {32'd0, rsp_data[31:0]}, 64'h14);

    // Wrap-around add
    req_valid = 2'b01; set0(1'b0, 32'hFFFF_FFFF, 32'h2, 3'b000); cyc();
    chk("wrap", {32'd0, rsp_data[31:0]}, 64'h1);

    // Reset while requester 1 is granted
    req_valid = 2'b11;
    #1 chk("mid_grant1", {62'd0, req_ready}, 64'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_valid", {62'd0, rsp_valid}, 64'd0);
    chk("mid_rst_data", rsp_data, 64'd0);
    #1 chk("post_rst_tie", {62'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 2'b00;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
